// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared access-type codes, FSM encodings and size decode
package load_store_unit_pkg;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  // Access size: 0 byte, 1 half, 2 word; unused codes fall back to word
  function automatic logic [1:0] ls_size(input logic [2:0] t);
    return (t == LS_B || t == LS_BU) ? 2'd0 : (t == LS_H || t == LS_HU) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/load_store_unit_ls_align.sv
// ls_align: byte-lane enables, store replication, alignment check and load extraction
module ls_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  output logic [31:0] ld_data_o
);
  logic [1:0]  sz, lsz;
  logic [31:0] sh;
  logic        sgn;
  assign sz  = ls_size(type_i);
  assign lsz = ls_size(ld_type_i);
  assign sgn = ld_type_i == LS_B || ld_type_i == LS_H;
  assign sh  = rdata_i >> {ld_off_i, 3'b000};
  assign misaligned_o = sz == 2'd2 ? |off_i : sz == 2'd1 && off_i[0];
  assign be_o = sz == 2'd2 ? 4'hF : (sz == 2'd1 ? 4'b0011 : 4'b0001) << off_i;
  assign wdata_o = sz == 2'd2 ? wdata_i : sz == 2'd1 ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
  assign ld_data_o = lsz == 2'd0 ? {{24{sgn & sh[7]}}, sh[7:0]}
                   : lsz == 2'd1 ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage issuing byte/half/word accesses over a req/ack bus
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  ls_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       type_q;
  logic [1:0]       off_q;
  logic             we_q, err_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       be_q;
  logic             mis, go, waiting, timeout, fin;
  logic [3:0]       be_c;
  logic [31:0]      wrep, ld;
  ls_align u_align (
    .type_i(ls_type), .off_i(addr[1:0]), .wdata_i(wdata),
    .ld_type_i(type_q), .ld_off_i(off_q), .rdata_i(bus_rdata),
    .be_o(be_c), .wdata_o(wrep), .misaligned_o(mis), .ld_data_o(ld)
  );
  // go is gated by rst so an asserted reset drops stall in the same cycle
  assign misaligned = (mem_read | mem_write) & mis;
  assign go         = rst && state_q == S_IDLE && (mem_read | mem_write) && !mis;
  assign waiting    = state_q == S_WAIT;
  assign timeout    = waiting && !bus_ack && cnt_q == CNT_W'(TIMEOUT - 1);
  assign fin        = waiting && (bus_ack || timeout);
  assign stall      = go | waiting;
  assign bus_req    = waiting;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign rdata      = rdata_q;
  assign bus_error  = err_q;
  // Next state: DONE always returns to IDLE so the access is never reissued
  always_comb begin
    state_d = state_q == S_IDLE ? (go ? S_WAIT : S_IDLE) : waiting ? (fin ? S_DONE : S_WAIT) : S_IDLE;
  end
  // State, timeout counter, latched request and load result
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= waiting ? cnt_q + CNT_W'(1) : '0;
      err_q   <= timeout;
      if (go) begin
        we_q    <= mem_write;
        addr_q  <= {addr[31:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wrep;
        type_q  <= ls_type;
        off_q   <= addr[1:0];
      end else if (fin) begin
        we_q <= 1'b0;
      end
      if (waiting && bus_ack && !we_q) rdata_q <= ld;
      else if (timeout) rdata_q <= '0;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench driving directed loads/stores over the bus
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  ls_type = '0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, misaligned, bus_error, bus_req, bus_we;
  logic [3:0]  bus_be;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;
  exp_t sb[$];

  load_store_unit #(.TIMEOUT(8), .CNT_W(16)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .ls_type(ls_type), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .misaligned(misaligned), .bus_error(bus_error), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks bus fields on the first WAIT cycle, result fields in DONE
  logic prev_req = 1'b0;
  int   stalls = 0;
  always @(negedge CLOCK_50) begin
    exp_t e;
    if (!rst) begin
      prev_req = 1'b0;
      stalls = 0;
    end else begin
      if (stall) stalls++;
      if (bus_req && !prev_req) begin
        if (sb.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          chk("bus_addr", bus_addr, sb[0].addr);
          chk("bus_be", {28'd0, bus_be}, {28'd0, sb[0].be});
          chk("bus_we", {31'd0, bus_we}, {31'd0, sb[0].we});
          if (sb[0].we) chk("bus_wdata", bus_wdata, sb[0].wdata);
        end
      end
      if (!bus_req && prev_req) begin
        if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("bus_error", {31'd0, bus_error}, {31'd0, e.err});
          chk("stall_cycles", stalls, e.stalls);
          chk("done_we_low", {31'd0, bus_we}, 32'd0);
        end
        stalls = 0;
      end else begin
        chk("err_quiet", {31'd0, bus_error}, 32'd0);
      end
      prev_req = bus_req;
    end
  end

  // k = WAIT cycle carrying bus_ack; k = 0 means never ack (timeout after 8)
  task automatic op(input logic wr, input logic [2:0] t, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] brd, input int k,
                    input logic [3:0] e_be, input logic [31:0] e_wd,
                    input logic [31:0] e_rd, input logic e_err);
    exp_t e;
    int c;
    e.addr = {a[31:2], 2'b00};
    e.be = e_be;
    e.we = wr;
    e.wdata = e_wd;
    e.rdata = e_rd;
    e.err = e_err;
    e.stalls = (k != 0 ? k : 8) + 1;
    sb.push_back(e);
    @(posedge CLOCK_50); #1;
    mem_read = !wr; mem_write = wr; ls_type = t; addr = a; wdata = wd; bus_rdata = brd;
    c = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLOCK_50); #1;
      if (!bus_req) break;
      c++;
      bus_ack = (c == k);
    end
    bus_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    chk("req_cycles", c, k != 0 ? k : 8);
  endtask

  initial begin
    exp_t e;
    #5;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {31'd0, bus_we}, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_err", {31'd0, bus_error}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge CLOCK_50); #1 rst = 1'b1;
    op(0, LS_W,  32'h100, 32'h0,      32'hDEADBEEF, 1, 4'hF, 32'h0,      32'hDEADBEEF, 0);
    op(0, LS_B,  32'h103, 32'h0,      32'h80123456, 2, 4'h8, 32'h0,      32'hFFFFFF80, 0);
    op(0, LS_BU, 32'h103, 32'h0,      32'h80123456, 1, 4'h8, 32'h0,      32'h00000080, 0);
    op(1, LS_H,  32'h202, 32'h0000ABCD, 32'h0,      4, 4'hC, 32'hABCDABCD, 32'h00000080, 0);
    op(0, LS_H,  32'h102, 32'h0,      32'h80017FFF, 1, 4'hC, 32'h0,      32'hFFFF8001, 0);
    op(0, LS_HU, 32'h100, 32'h0,      32'h1234F00D, 3, 4'h3, 32'h0,      32'h0000F00D, 0);
    op(1, LS_B,  32'h301, 32'h000000A5, 32'h0,      1, 4'h2, 32'hA5A5A5A5, 32'h0000F00D, 0);
    op(1, LS_W,  32'h400, 32'h01234567, 32'h0,      2, 4'hF, 32'h01234567, 32'h0000F00D, 0);
    op(0, LS_W,  32'h500, 32'h0,      32'h11111111, 0, 4'hF, 32'h0,      32'h00000000, 1);
    op(0, 3'b110, 32'h704, 32'h0,     32'h55AA55AA, 1, 4'hF, 32'h0,      32'h55AA55AA, 0);
    // misaligned accesses never reach the bus
    @(posedge CLOCK_50); #1;
    mem_read = 1'b1; ls_type = LS_W; addr = 32'h101;
    @(negedge CLOCK_50);
    chk("mis_lw", {31'd0, misaligned}, 32'd1);
    chk("mis_lw_stall", {31'd0, stall}, 32'd0);
    @(posedge CLOCK_50); #1;
    ls_type = LS_H; addr = 32'h103;
    @(negedge CLOCK_50);
    chk("mis_lh", {31'd0, misaligned}, 32'd1);
    chk("mis_lh_req", {31'd0, bus_req}, 32'd0);
    @(posedge CLOCK_50); #1 mem_read = 1'b0;
    @(negedge CLOCK_50);
    chk("mis_clear", {31'd0, misaligned}, 32'd0);
    chk("mis_rdata", rdata, 32'h55AA55AA);
    // stray ack while idle is ignored
    @(posedge CLOCK_50); #1 bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(posedge CLOCK_50); #1 bus_ack = 1'b0;
    @(negedge CLOCK_50);
    chk("stray_ack_req", {31'd0, bus_req}, 32'd0);
    chk("stray_ack_rdata", rdata, 32'h55AA55AA);
    // reset in the second WAIT cycle aborts at once
    e.addr = 32'h800; e.be = 4'hF; e.we = 1'b0; e.wdata = 32'h0;
    e.rdata = 32'h0; e.err = 1'b0; e.stalls = 0;
    sb.push_back(e);
    @(posedge CLOCK_50); #1 mem_read = 1'b1; ls_type = LS_W; addr = 32'h800;
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1 rst = 1'b0; sb.delete();
    #1;
    chk("rstw_req", {31'd0, bus_req}, 32'd0);
    chk("rstw_stall", {31'd0, stall}, 32'd0);
    chk("rstw_rdata", rdata, 32'd0);
    mem_read = 1'b0;
    @(posedge CLOCK_50); #1 rst = 1'b1;
    op(0, LS_W, 32'h600, 32'h0, 32'hCAFEF00D, 3, 4'hF, 32'h0, 32'hCAFEF00D, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CLOCK_50);
    if (sb.size() != 0) chk("sb_drained", sb.size(), 32'd0);
    @(posedge CLOCK_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage downstream of the single-cycle datapath: consumes the ALU result as the effective address and register operand 2 as store data.
- Performs byte/half/word loads and stores over a req/ack word bus to data memory.
- Stalls the core's PC update while a bus transaction is outstanding.
- Returns aligned, sign- or zero-extended load data for register write-back.

Parameters:
- TIMEOUT, 255, max cycles in WAIT without bus_ack before the access is aborted with bus_error (range 1..65535).
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store; wins if both are high
- ls_type  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; sb/sh/sw use 000/001/010; 011/110/111 behave as 010
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (register operand 2)
- rdata  out  32  load result, valid in DONE, held until the next DONE
- stall  out  1  core must hold PC and all inputs stable
- misaligned  out  1  combinational: access requested with bad alignment
- bus_error  out  1  one-cycle pulse in DONE after a timeout
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write strobe
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables, little-endian
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, sampled with bus_ack
- bus_ack  in  1  one-cycle completion

Behaviour:
- Reset (async, immediate): state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, bus_error=0, counter=0.
- op = mem_read|mem_write.
- Alignment rule: half needs addr[0]=0; word needs addr[1:0]=0.
- misaligned = op & bad alignment. A misaligned access never enters WAIT, stall=0, rdata unchanged, and the core advances.
- FSM, 3 states:
  - IDLE: stall = op & !misaligned. If so, latch bus_we, bus_addr, bus_be, bus_wdata, ls_type and addr[1:0] -> WAIT.
  - WAIT: bus_req=1, stall=1, counter increments each cycle.
    - On bus_ack: for reads, capture the extracted bus_rdata into rdata -> DONE.
    - If counter reaches TIMEOUT with no ack: rdata=0, bus_error=1 -> DONE.
    - bus_req and bus_we drop in the cycle after ack.
  - DONE: stall=0, so the core's PC advances on this edge. Always -> IDLE; never reissues the access. Counter clears.
- Latency:
  - ack in the first WAIT cycle gives 3 cycles (IDLE, WAIT, DONE).
  - ack after k WAIT cycles gives k+2 cycles.
  - Stores update rdata? No: rdata holds its old value.
- Store lanes:
  - sb: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - sh: be = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - sw: be = 1111.
- Load extraction: shift bus_rdata right by 8*addr[1:0], then extend by ls_type (lb/lh sign-extend, lbu/lhu zero-extend).
- A bus_ack arriving outside WAIT is ignored.
- Reset mid-WAIT aborts immediately. No further bus_req is issued, and memory outcome is undefined.
- Input changes during stall are a core protocol violation; the latched copies are used regardless.

Decomposition:
- Shared package:
  - ls_type codes: LS_B, LS_H, LS_W, LS_BU, LS_HU.
  - FSM state encodings: S_IDLE, S_WAIT, S_DONE.
- One sub-module, ls_align (purely combinational): produces be, replicated wdata, misaligned, and extracted/extended load data from ls_type, addr[1:0] and data.

Test Plan:
- lw, addr=0x100, bus_rdata=0xDEADBEEF, ack in the 1st WAIT cycle -> bus_addr=0x100, be=1111, stall high 2 cycles, rdata=0xDEADBEEF in DONE.
- lb at 0x103 and lbu at 0x103, bus_rdata=0x80123456 -> be=1000; rdata=0xFFFFFF80 and 0x00000080 respectively.
- sh at 0x202, wdata=0x0000ABCD, ack after 4 cycles -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, stall high 5 cycles, rdata unchanged.
- lw at 0x101 -> misaligned=1, stall=0, bus_req never asserted.
- TIMEOUT=8, no ack -> bus_req held 8 cycles, then DONE with bus_error=1 and rdata=0, then IDLE.
- rst driven low in the 2nd WAIT cycle -> bus_req=0 and stall=0 within the same cycle; a clean lw completes after rst is released.
